// File: rtl/aes_pkg.sv
// AES shared types, S-box table and GF(2^8) helpers.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_OUT
    } fsm_t;

    // Entry 0 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t subword(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rotword(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic int NR_OF(input int kb);
        return (kb == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// Valid/ready bundle between block source, AES core and ciphertext sink.
interface aes_encrypt_core_if
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    state_t              plaintext;
    logic [KEY_BITS-1:0] key;
    state_t              ciphertext;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, ciphertext, out_valid
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, ciphertext, out_valid
    );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    input  logic   last,
    output state_t nxt
);
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sbox(st[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c + 0] = xtime(sr[4*c]) ^ xtime(sr[4*c + 1]) ^ sr[4*c + 1]
                        ^ sr[4*c + 2] ^ sr[4*c + 3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c + 1]) ^ xtime(sr[4*c + 2])
                        ^ sr[4*c + 2] ^ sr[4*c + 3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c + 1] ^ xtime(sr[4*c + 2])
                        ^ xtime(sr[4*c + 3]) ^ sr[4*c + 3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c + 1]
                        ^ sr[4*c + 2] ^ xtime(sr[4*c + 3]);
        end
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            nxt[127 - 8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127 - 8*i -: 8];
        end
    end
endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/256 encryptor, one round per clock, keys expanded on the fly.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic              clk,
    input  logic              rst,
    aes_encrypt_core_if.slave bus
);
    localparam int         NK = KEY_BITS / 32;
    localparam logic [3:0] NR = 4'(NR_OF(KEY_BITS));

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
    end

    fsm_t       fsm, fsm_nxt;
    logic [3:0] cnt;
    logic [7:0] rcon, rcon_nxt;
    word_t      kw [NK];
    word_t      kw_nxt [NK];
    state_t     st, rk, rnd_out;
    logic       vld, ready, load;

    assign bus.in_ready   = ready;
    assign bus.out_valid  = vld;
    assign bus.ciphertext = st;
    assign load           = bus.in_valid & ready;

    always_comb begin
        fsm_nxt = fsm;
        ready   = 1'b0;
        unique case (fsm)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) fsm_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (cnt == NR) fsm_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    ready   = 1'b1;
                    fsm_nxt = bus.in_valid ? S_ROUND : S_IDLE;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    if (NK == 8) begin : g_k256
        word_t g [8];
        word_t t0, t1;
        // Odd rounds reuse the upper half; even rounds roll the whole window.
        always_comb begin
            t0   = subword(rotword(kw[7])) ^ {rcon, 24'h0};
            g[0] = kw[0] ^ t0;
            for (int i = 1; i < 4; i++) g[i] = kw[i] ^ g[i-1];
            t1   = subword(g[3]);
            g[4] = kw[4] ^ t1;
            for (int i = 5; i < 8; i++) g[i] = kw[i] ^ g[i-1];
            if (cnt[0]) begin
                rk       = {kw[4], kw[5], kw[6], kw[7]};
                rcon_nxt = rcon;
                for (int i = 0; i < 8; i++) kw_nxt[i] = kw[i];
            end else begin
                rk       = {g[0], g[1], g[2], g[3]};
                rcon_nxt = xtime(rcon);
                for (int i = 0; i < 8; i++) kw_nxt[i] = g[i];
            end
        end
    end else begin : g_k128
        word_t t0;
        always_comb begin
            t0        = subword(rotword(kw[3])) ^ {rcon, 24'h0};
            kw_nxt[0] = kw[0] ^ t0;
            for (int i = 1; i < 4; i++) kw_nxt[i] = kw[i] ^ kw_nxt[i-1];
            rk       = {kw_nxt[0], kw_nxt[1], kw_nxt[2], kw_nxt[3]};
            rcon_nxt = xtime(rcon);
        end
    end

    aes_round u_round (
        .st   (st),
        .rk   (rk),
        .last (cnt == NR),
        .nxt  (rnd_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm  <= S_IDLE;
            cnt  <= '0;
            rcon <= 8'h01;
            st   <= '0;
            vld  <= 1'b0;
            for (int i = 0; i < NK; i++) kw[i] <= '0;
        end else begin
            fsm <= fsm_nxt;
            vld <= (fsm_nxt == S_OUT);
            if (load) begin
                st   <= bus.plaintext ^ bus.key[KEY_BITS-1 -: 128];
                cnt  <= 4'd1;
                rcon <= 8'h01;
                for (int i = 0; i < NK; i++) begin
                    kw[i] <= bus.key[KEY_BITS - 1 - 32*i -: 32];
                end
            end else if (fsm == S_ROUND) begin
                st   <= rnd_out;
                rcon <= rcon_nxt;
                for (int i = 0; i < NK; i++) kw[i] <= kw_nxt[i];
                if (cnt != NR) cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES block-cipher encryption core, one round per clock, parametrised for AES-128 or AES-256 keys. It replaces the fixed-width, handshake-free `encryptor` in the datapath. Round keys are expanded on the fly. Valid/ready handshakes on input and output let it sit between a plaintext source (UART/host loader) and a ciphertext sink with backpressure.

## Interface
- `KEY_BITS`, 128, key length; legal values are 128 and 256 only. Any other value is an elaboration error. `NR` is derived as 10 or 14.
- `clk`  in  1  single clock; all flops rise-edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  plaintext and key are presented.
- `in_ready`  out  1  core can accept a block this cycle.
- `plaintext`  in  128  block; `[127:120]` is state byte 0 (s[0,0]), column-major ordering as in FIPS-197.
- `key`  in  KEY_BITS  cipher key; MSB byte is key byte 0.
- `ciphertext`  out  128  result, same byte order as `plaintext`.
- `out_valid`  out  1  `ciphertext` is valid.
- `out_ready`  in  1  sink accepts `ciphertext`.

## Operation
- FSM states are IDLE, ROUND, OUT.
- **IDLE:** `in_ready`=1.
  - On `in_valid`: state ← `plaintext` ^ w[0..3].
  - Key window ← `key`.
  - Round counter ← 1, rcon ← 0x01, go to ROUND.
- **ROUND:**
  - Each cycle applies SubBytes, ShiftRows, MixColumns and AddRoundKey with the next round key.
  - The round where counter==NR omits MixColumns.
  - After the round NR edge, go to OUT.
- **Key expansion:** computed in the same cycle as the round that uses it.
  - AES-128: next 4 words = RotWord/SubWord/rcon chain; rcon ← xtime(rcon) each round.
  - AES-256: the window holds 8 words. Odd rounds use w[4..7] directly. Even rounds generate 8 new words: RotWord+SubWord+rcon on the first, SubWord-only on the fifth. rcon advances every second round.
- **OUT:** `out_valid`=1 and `ciphertext` is held stable until `out_ready`.
  - If `out_ready`: `in_ready`=1 combinationally in the same cycle.
  - If `in_valid` is also high, the new block loads and the FSM goes to ROUND (back-to-back). Otherwise it goes to IDLE.
- `in_valid` in ROUND is ignored (`in_ready`=0). Inputs are sampled only at the accept edge; changes afterwards have no effect.
- All arithmetic is GF(2^8) with polynomial 0x11B. The round counter is 4 bits and saturates at NR (no wrap).

## Timing
- **Reset (rst=0 at a rising edge):**
  - FSM=IDLE, `in_ready`=1 from the next cycle.
  - `out_valid`=0, `ciphertext`=0.
  - Counter=0, rcon=0x01, key window=0.
  - Reset mid-ROUND or in OUT abandons the block with no output.
- **Latency:** accept sampled at edge e0; `out_valid` is high from the cycle after edge e0+NR. That is 11 cycles for AES-128 and 15 for AES-256 when `out_ready` is held high.
- **Throughput:** one block per NR+1 cycles with `out_ready` held high and back-to-back `in_valid`.
- **Combinational paths:** `in_ready` depends on `out_ready` and the FSM only. `ciphertext` and `out_valid` are registered.
- **Stalls:** `out_ready`=0 indefinitely holds OUT. No data loss, and no new accept.

## Structure
- **Package `aes_pkg`:**
  - S-box function (256-entry constant) and `xtime`.
  - `NR_OF(KEY_BITS)` function and the FSM state enum.
  - Word/state typedefs: 32-bit word, 128-bit state.
- **Sub-module `aes_round`:** combinational SubBytes, ShiftRows, MixColumns (bypassed by `last` input) and AddRoundKey.
- **Top level:** FSM, counter, rcon and key-window registers, plus 4 SubWord S-boxes for key expansion.

## Test plan
- **FIPS-197 App. B, AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32, `out_valid` in cycle 11.
- **FIPS-197 App. C.1:** key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- **KEY_BITS=256, App. C.3:** key 000102…1f, same pt → 8ea2b7ca516745bfeafc49904b496089, `out_valid` in cycle 15.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after `out_valid` → `ciphertext` stable and `in_ready`=0 throughout. Then `out_ready`=1 with `in_valid`=1 → second block (C.1 vector) accepted in the same cycle, result 11 cycles later.
- **Reset mid-operation:** `rst`=0 at round 5 → next cycle `out_valid`=0, `ciphertext`=0, `in_ready`=1. A fresh App. B block then completes correctly.
- **Team demo vector:** pt 69206c6f766520636f6d706172636821, key 6d65677361797372617772746f796f75 → ciphertext equals the `user_encryption.py` reference output.
